// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_WIDTH    = 32;

    // Canonical NOP (addi x0, x0, 0) carried by fault entries
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0013;

    // Fault cause codes presented on if_fault_cause_o
    localparam logic FAULT_CAUSE_BUS_ERR  = 1'b0;
    localparam logic FAULT_CAUSE_MISALIGN = 1'b1;

    typedef enum logic {
        FETCH_ST_FETCH      = 1'b0,
        FETCH_ST_FAULT_WAIT = 1'b1
    } fetch_state_e;

    // One IF/ID queue entry
    typedef struct packed {
        logic                   fault;
        logic                   cause;
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small synchronous FIFO with push/pop/flush and occupancy.
// A flush empties the queue but still accepts a same-cycle push, so the
// pushed word becomes the only entry after the edge.
module fetch_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] occ
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [OCC_W-1:0] count;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pops are ignored while flushing and when empty; the owner guarantees
    // a push never lands on a full queue unless a pop happens alongside it.
    assign do_pop    = pop && (count != '0) && !flush;
    assign head_data = mem[rd_ptr];
    assign occ       = count;

    // Pointer and occupancy control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            wr_ptr <= push ? next_ptr(wr_ptr) : wr_ptr;
            count  <= OCC_W'(push);
        end else begin
            if (push)
                wr_ptr <= next_ptr(wr_ptr);
            if (do_pop)
                rd_ptr <= next_ptr(rd_ptr);
            count <= count + OCC_W'(push) - OCC_W'(do_pop);
        end
    end

    // Storage write; contents are qualified by occupancy so need no reset
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: owns the PC, issues in-order word fetches to imem, buffers
// {pc, instr} pairs and hands them to decode; flushes on EX redirects.
// Optional: define FETCH_MISALIGN_CHECK_EN to turn a misaligned redirect
// target into a fault entry (cause 1) instead of silently aligning it.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  FQ_DEPTH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req_valid_o,
    input  logic                   imem_req_ready_i,
    output logic [PC_WIDTH-1:0]    imem_req_addr_o,
    input  logic                   imem_rsp_valid_i,
    input  logic [INSTR_WIDTH-1:0] imem_rsp_data_i,
    input  logic                   imem_rsp_err_i,
    input  logic                   redirect_i,
    input  logic [PC_WIDTH-1:0]    redirect_pc_i,
    output logic                   if_valid_o,
    input  logic                   if_ready_i,
    output logic [INSTR_WIDTH-1:0] if_instr_o,
    output logic [PC_WIDTH-1:0]    if_pc_o,
    output logic                   if_fault_o,
    output logic                   if_fault_cause_o
);

    localparam int CNT_W   = $clog2(FQ_DEPTH + 1);
    localparam int ENTRY_W = $bits(fq_entry_t);

    fetch_state_e        state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q;
    logic [CNT_W-1:0]    out_q;
    logic [CNT_W-1:0]    drop_q;
    logic [CNT_W-1:0]    fq_occ;
    logic [CNT_W-1:0]    pc_fifo_occ_unused;

    logic                credit_ok;
    logic                req_valid;
    logic                req_fire;
    logic                rsp_accept;
    logic                redirect_misalign;
    logic [PC_WIDTH-1:0] redirect_pc_eff;
    logic [PC_WIDTH-1:0] rsp_pc;
    logic                fq_push;
    logic                fq_pop;
    fq_entry_t           fq_push_entry;
    fq_entry_t           fq_head;
    logic                unused_bits;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_pc_eff   = redirect_pc_i;
    assign redirect_misalign = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign if_fault_cause_o  = if_valid_o & fq_head.cause;
    assign unused_bits       = 1'b0;
`else
    assign redirect_pc_eff   = {redirect_pc_i[PC_WIDTH-1:2], 2'b00};
    assign redirect_misalign = 1'b0;
    assign if_fault_cause_o  = 1'b0;
    assign unused_bits       = ^{fq_head.cause, redirect_pc_i[1:0]};
`endif

    // Credit uses registered counts only: every in-flight request owns a slot
    assign credit_ok  = (int'(out_q) + int'(fq_occ)) < FQ_DEPTH;
    assign req_fire   = req_valid && imem_req_ready_i;
    assign rsp_accept = imem_rsp_valid_i && (drop_q == '0) && !redirect_i;
    assign fq_pop     = if_valid_o && if_ready_i;

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = pc_q;

    // FSM next state and request valid
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        case (state_q)
            FETCH_ST_FETCH:      req_valid = rst_n && !redirect_i && credit_ok;
            FETCH_ST_FAULT_WAIT: req_valid = 1'b0;
            default:             req_valid = 1'b0;
        endcase
        if (rsp_accept && imem_rsp_err_i)
            state_d = FETCH_ST_FAULT_WAIT;
        if (redirect_i)
            state_d = redirect_misalign ? FETCH_ST_FAULT_WAIT : FETCH_ST_FETCH;
    end

    // FSM state, PC and outstanding/drop counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FETCH_ST_FETCH;
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            if (redirect_i) begin
                // Everything still in flight is stale; no request fires here
                pc_q   <= redirect_pc_eff;
                out_q  <= out_q - CNT_W'(imem_rsp_valid_i);
                drop_q <= out_q - CNT_W'(imem_rsp_valid_i);
            end else begin
                if (req_fire)
                    pc_q <= pc_q + PC_WIDTH'(4);
                out_q <= out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid_i);
                if (imem_rsp_valid_i && (drop_q != '0))
                    drop_q <= drop_q - CNT_W'(1);
            end
        end
    end

    // Queue entry built from the response, or a misaligned-target fault
    always_comb begin
        fq_push             = rsp_accept;
        fq_push_entry.fault = 1'b0;
        fq_push_entry.cause = FAULT_CAUSE_BUS_ERR;
        fq_push_entry.pc    = rsp_pc;
        fq_push_entry.instr = imem_rsp_data_i;
        if (rsp_accept && imem_rsp_err_i) begin
            fq_push_entry.fault = 1'b1;
            fq_push_entry.instr = NOP_INSTR;
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_misalign) begin
            fq_push             = 1'b1;
            fq_push_entry.fault = 1'b1;
            fq_push_entry.cause = FAULT_CAUSE_MISALIGN;
            fq_push_entry.pc    = redirect_pc_i;
            fq_push_entry.instr = NOP_INSTR;
        end
`endif
    end

    // PCs of requests whose responses are still owed, in issue order
    fetch_queue #(
        .WIDTH (PC_WIDTH),
        .DEPTH (FQ_DEPTH)
    ) u_pc_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_i),
        .push      (req_fire),
        .push_data (pc_q),
        .pop       (rsp_accept),
        .head_data (rsp_pc),
        .occ       (pc_fifo_occ_unused)
    );

    // Returned entries waiting for decode
    fetch_queue #(
        .WIDTH (ENTRY_W),
        .DEPTH (FQ_DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_i),
        .push      (fq_push),
        .push_data (fq_push_entry),
        .pop       (fq_pop),
        .head_data (fq_head),
        .occ       (fq_occ)
    );

    // Payload is masked while empty so decode sees zeros, not stale storage
    assign if_valid_o = (fq_occ != '0);
    assign if_instr_o = if_valid_o ? fq_head.instr : '0;
    assign if_pc_o    = if_valid_o ? fq_head.pc : '0;
    assign if_fault_o = if_valid_o & fq_head.fault;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a fixed-latency imem model.
`timescale 1ns/1ps
module tb_instr_fetch;
    import instr_fetch_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   imem_req_valid_o;
    logic                   imem_req_ready_i;
    logic [PC_WIDTH-1:0]    imem_req_addr_o;
    logic                   imem_rsp_valid_i;
    logic [INSTR_WIDTH-1:0] imem_rsp_data_i;
    logic                   imem_rsp_err_i;
    logic                   redirect_i;
    logic [PC_WIDTH-1:0]    redirect_pc_i;
    logic                   if_valid_o;
    logic                   if_ready_i;
    logic [INSTR_WIDTH-1:0] if_instr_o;
    logic [PC_WIDTH-1:0]    if_pc_o;
    logic                   if_fault_o;
    logic                   if_fault_cause_o;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .imem_req_valid_o (imem_req_valid_o),
        .imem_req_ready_i (imem_req_ready_i),
        .imem_req_addr_o  (imem_req_addr_o),
        .imem_rsp_valid_i (imem_rsp_valid_i),
        .imem_rsp_data_i  (imem_rsp_data_i),
        .imem_rsp_err_i   (imem_rsp_err_i),
        .redirect_i       (redirect_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_instr_o       (if_instr_o),
        .if_pc_o          (if_pc_o),
        .if_fault_o       (if_fault_o),
        .if_fault_cause_o (if_fault_cause_o)
    );

    typedef struct {
        logic [PC_WIDTH-1:0] addr;
        int                  due;
    } pend_t;

    typedef struct {
        logic [PC_WIDTH-1:0]    pc;
        logic [INSTR_WIDTH-1:0] instr;
        logic                   fault;
        logic                   cause;
        int                     cyc;
    } pop_t;

    pend_t               pend[$];
    logic [PC_WIDTH-1:0] req_log[$];
    pop_t                pop_log[$];

    int                  cyc;
    int                  rel_cyc;
    int                  mem_lat;
    logic                err_en;
    logic [PC_WIDTH-1:0] err_addr;
    logic                last_req_valid;
    logic [PC_WIDTH-1:0] last_req_addr;
    int                  n_checks;
    int                  n_fail;

    function automatic logic [INSTR_WIDTH-1:0] instr_of(input logic [PC_WIDTH-1:0] a);
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock cycle: drive imem response, log handshakes, advance to next negedge
    task automatic tick();
        pend_t p;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        if (rst_n && pend.size() > 0 && pend[0].due <= cyc) begin
            p = pend.pop_front();
            imem_rsp_valid_i = 1'b1;
            imem_rsp_data_i  = instr_of(p.addr);
            imem_rsp_err_i   = err_en && (p.addr == err_addr);
        end
        #1;
        last_req_valid = imem_req_valid_o;
        last_req_addr  = imem_req_addr_o;
        if (imem_req_valid_o && imem_req_ready_i) begin
            pend.push_back('{imem_req_addr_o, cyc + mem_lat});
            req_log.push_back(imem_req_addr_o);
        end
        if (if_valid_o && if_ready_i)
            pop_log.push_back('{if_pc_o, if_instr_o, if_fault_o, if_fault_cause_o, cyc});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        redirect_i = 1'b0;
        repeat (3) tick();
        pend.delete();
        req_log.delete();
        pop_log.delete();
    endtask

    task automatic release_reset();
        rst_n   = 1'b1;
        rel_cyc = cyc;
    endtask

    task automatic test_reset();
        mem_lat = 1;
        apply_reset();
        release_reset();
        if_ready_i = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (if_valid_o !== 1'b1) begin n_fail++; $display("FAIL prefill_valid: got %0b expected 1", if_valid_o); end
        apply_reset();
        n_checks++;
        if (imem_req_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %0b expected 0", imem_req_valid_o); end
        n_checks++;
        if (imem_req_addr_o !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h expected 00000000", imem_req_addr_o); end
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_if_valid: got %0b expected 0", if_valid_o); end
        n_checks++;
        if (if_fault_o !== 1'b0 || if_fault_cause_o !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b/%0b expected 0/0", if_fault_o, if_fault_cause_o); end
        n_checks++;
        if (if_instr_o !== 32'h0 || if_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_payload: got %h/%h expected 0/0", if_instr_o, if_pc_o); end
    endtask

    task automatic test_stream();
        if_ready_i = 1'b1;
        release_reset();
        repeat (8) tick();
        n_checks++;
        if (req_log.size() != 8) begin n_fail++; $display("FAIL stream_req_count: got %0d expected 8", req_log.size()); end
        for (int i = 0; i < 4 && i < req_log.size(); i++) begin
            n_checks++;
            if (req_log[i] !== 32'(4 * i)) begin n_fail++; $display("FAIL stream_req_addr[%0d]: got %h expected %h", i, req_log[i], 32'(4 * i)); end
        end
        n_checks++;
        if (pop_log.size() != 6) begin n_fail++; $display("FAIL stream_pop_count: got %0d expected 6", pop_log.size()); end
        for (int i = 0; i < 4 && i < pop_log.size(); i++) begin
            n_checks++;
            if (pop_log[i].pc !== 32'(4 * i) || pop_log[i].cyc != rel_cyc + 2 + i) begin
                n_fail++;
                $display("FAIL stream_pop[%0d]: got pc %h cyc %0d expected pc %h cyc %0d", i, pop_log[i].pc, pop_log[i].cyc - rel_cyc, 32'(4 * i), 2 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int n_before;
        logic [PC_WIDTH-1:0] exp_pc;
        n_before   = pop_log.size();
        exp_pc     = 32'(4 * n_before);
        if_ready_i = 1'b0;
        repeat (10) tick();
        n_checks++;
        if (last_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stopped: got %0b expected 0", last_req_valid); end
        n_checks++;
        if (req_log.size() - pop_log.size() != 3) begin n_fail++; $display("FAIL bp_credit: got %0d expected 3", req_log.size() - pop_log.size()); end
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== exp_pc) begin n_fail++; $display("FAIL bp_hold: got valid %0b pc %h expected 1 %h", if_valid_o, if_pc_o, exp_pc); end
        if_ready_i = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < pop_log.size(); i++) begin
            n_checks++;
            if (pop_log[i].pc !== 32'(4 * i) || pop_log[i].instr !== instr_of(32'(4 * i))) begin
                n_fail++;
                $display("FAIL bp_seq[%0d]: got pc %h instr %h expected pc %h", i, pop_log[i].pc, pop_log[i].instr, 32'(4 * i));
            end
        end
    endtask

    task automatic test_redirect_stale();
        mem_lat = 3;
        imem_req_ready_i = 1'b1;
        if_ready_i = 1'b1;
        apply_reset();
        release_reset();
        repeat (2) tick();
        imem_req_ready_i = 1'b0;
        redirect_i       = 1'b1;
        redirect_pc_i    = 32'h100;
        tick();
        n_checks++;
        if (last_req_valid !== 1'b0) begin n_fail++; $display("FAIL stale_redirect_valid: got %0b expected 0", last_req_valid); end
        redirect_i       = 1'b0;
        imem_req_ready_i = 1'b1;
        tick();
        n_checks++;
        if (last_req_valid !== 1'b1 || last_req_addr !== 32'h100) begin n_fail++; $display("FAIL stale_first_req: got %0b %h expected 1 00000100", last_req_valid, last_req_addr); end
        repeat (8) tick();
        n_checks++;
        if (pop_log.size() == 0) begin
            n_fail++; $display("FAIL stale_first_pop: got none expected pc 00000100");
        end else if (pop_log[0].pc !== 32'h100 || pop_log[0].instr !== instr_of(32'h100) || pop_log[0].cyc != rel_cyc + 7) begin
            n_fail++; $display("FAIL stale_first_pop: got pc %h instr %h cyc %0d expected 00000100 %h 7", pop_log[0].pc, pop_log[0].instr, pop_log[0].cyc - rel_cyc, instr_of(32'h100));
        end
        mem_lat = 1;
    endtask

    task automatic test_bus_error();
        mem_lat  = 1;
        err_en   = 1'b1;
        err_addr = 32'h8;
        apply_reset();
        release_reset();
        repeat (10) tick();
        n_checks++;
        if (req_log.size() != 4 || last_req_valid !== 1'b0) begin n_fail++; $display("FAIL err_req_stop: got %0d reqs valid %0b expected 4 0", req_log.size(), last_req_valid); end
        n_checks++;
        if (pop_log.size() < 3) begin
            n_fail++; $display("FAIL err_entry: got %0d pops expected at least 3", pop_log.size());
        end else if (pop_log[2].pc !== 32'h8 || pop_log[2].fault !== 1'b1 || pop_log[2].cause !== 1'b0 || pop_log[2].instr !== 32'h13) begin
            n_fail++; $display("FAIL err_entry: got pc %h fault %0b cause %0b instr %h expected 00000008 1 0 00000013", pop_log[2].pc, pop_log[2].fault, pop_log[2].cause, pop_log[2].instr);
        end
        n_checks++;
        if (pop_log.size() < 2 || pop_log[1].fault !== 1'b0) begin n_fail++; $display("FAIL err_prev_clean: expected pc 4 entry without fault"); end
        err_en        = 1'b0;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_i = 1'b0;
        tick();
        n_checks++;
        if (last_req_valid !== 1'b1 || last_req_addr !== 32'h40) begin n_fail++; $display("FAIL err_resume_req: got %0b %h expected 1 00000040", last_req_valid, last_req_addr); end
        repeat (3) tick();
        n_checks++;
        if (pop_log.size() < 5 || pop_log[4].pc !== 32'h40 || pop_log[4].fault !== 1'b0) begin n_fail++; $display("FAIL err_resume_pop: got %0d pops expected entry pc 00000040 at index 4", pop_log.size()); end
    endtask

    task automatic test_redirect_collide();
        int n;
        mem_lat = 1;
        apply_reset();
        release_reset();
        repeat (6) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        tick();
        redirect_i = 1'b0;
        n_checks++;
        if (pop_log.size() == 0 || pop_log[pop_log.size() - 1].cyc != cyc - 1) begin n_fail++; $display("FAIL collide_pop_in_redirect: got %0d pops expected a pop in cycle %0d", pop_log.size(), cyc - 1); end
        n_checks++;
        if (if_valid_o !== 1'b0) begin n_fail++; $display("FAIL collide_empty: got %0b expected 0", if_valid_o); end
        n = pop_log.size();
        tick();
        n_checks++;
        if (last_req_valid !== 1'b1 || last_req_addr !== 32'h200) begin n_fail++; $display("FAIL collide_first_req: got %0b %h expected 1 00000200", last_req_valid, last_req_addr); end
        repeat (3) tick();
        n_checks++;
        if (pop_log.size() <= n || pop_log[n].pc !== 32'h200) begin n_fail++; $display("FAIL collide_next_pop: got %0d pops expected pc 00000200 at index %0d", pop_log.size(), n); end
    endtask

    task automatic test_misalign();
        int n;
        int r;
        mem_lat = 1;
        apply_reset();
        release_reset();
        repeat (4) tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
        redirect_i = 1'b0;
        n = pop_log.size();
        r = req_log.size();
`ifdef FETCH_MISALIGN_CHECK_EN
        n_checks++;
        if (if_valid_o !== 1'b1 || if_pc_o !== 32'h102 || if_fault_o !== 1'b1 || if_fault_cause_o !== 1'b1 || if_instr_o !== 32'h13) begin
            n_fail++; $display("FAIL misalign_entry: got v%0b pc %h f%0b c%0b instr %h expected 1 00000102 1 1 00000013", if_valid_o, if_pc_o, if_fault_o, if_fault_cause_o, if_instr_o);
        end
        repeat (4) tick();
        n_checks++;
        if (req_log.size() != r || last_req_valid !== 1'b0) begin n_fail++; $display("FAIL misalign_no_req: got %0d new reqs expected 0", req_log.size() - r); end
`else
        tick();
        n_checks++;
        if (last_req_valid !== 1'b1 || last_req_addr !== 32'h100) begin n_fail++; $display("FAIL align_req: got %0b %h expected 1 00000100", last_req_valid, last_req_addr); end
        repeat (3) tick();
        n_checks++;
        if (pop_log.size() <= n || pop_log[n].pc !== 32'h100 || pop_log[n].fault !== 1'b0 || pop_log[n].cause !== 1'b0) begin
            n_fail++; $display("FAIL align_pop: got %0d pops expected clean pc 00000100 at index %0d", pop_log.size(), n);
        end
`endif
    endtask

    initial begin
        rst_n            = 1'b0;
        imem_req_ready_i = 1'b1;
        imem_rsp_valid_i = 1'b0;
        imem_rsp_data_i  = '0;
        imem_rsp_err_i   = 1'b0;
        redirect_i       = 1'b0;
        redirect_pc_i    = '0;
        if_ready_i       = 1'b0;
        cyc              = 0;
        rel_cyc          = 0;
        mem_lat          = 1;
        err_en           = 1'b0;
        err_addr         = '0;
        last_req_valid   = 1'b0;
        last_req_addr    = '0;
        n_checks         = 0;
        n_fail           = 0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_bus_error();
        test_redirect_collide();
        test_misalign();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
